// File: rtl/rtc_bus_pkg.sv
// Shared state encoding and strobe levels for the RTC bus master.
// Pure definitions: no logic, no latency, no backpressure.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP_A,
    S_DATA,
    S_GAP_D,
    S_DONE
  } state_t;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter; tc_o flags the last cycle of a loaded phase.
// Load takes effect next cycle; a load of N gives N cycles ending with tc_o high.
module rtc_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/rtc_bus_master.sv
// Read/write burst engine for a multiplexed AD/CS/RD/WR RTC bus, all outputs registered.
// Outputs follow req by one cycle; each beat is 2*(T_PULSE+T_GAP) cycles; req while busy is dropped.
module rtc_bus_master
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int T_PULSE = 4,
  parameter int T_GAP   = 2,
  parameter int LEN_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wtake,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              ad_n,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in
);

  localparam int PH_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  state_t            state_q, state_d;
  logic              rw_q;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, beat_q;
  logic              abort_seen_q;
  logic              busy_q, done_q, aborted_q, wtake_q, rvalid_q;
  logic [DATA_W-1:0] rdata_q, bus_out_q;
  logic              ad_n_q, cs_n_q, rd_n_q, wr_n_q, bus_oe_q;

  logic              tmr_load, tmr_tc;
  logic [PH_W-1:0]   tmr_val;
  logic              wtake_d, rvalid_d, more, abort_any;
  logic [LEN_W:0]    beat_nx;

  rtc_phase_timer #(.W(PH_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  assign beat_nx   = {1'b0, beat_q} + {{LEN_W{1'b0}}, 1'b1};
  assign more      = beat_nx < {1'b0, len_q};
  assign abort_any = abort_seen_q | abort;

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = PH_W'(T_PULSE);
    addr_d   = addr_q;
    wtake_d  = 1'b0;
    rvalid_d = 1'b0;
    case (state_q)
      S_IDLE: if (req) begin
        state_d  = S_ADDR;
        tmr_load = 1'b1;
        addr_d   = addr;
      end
      S_ADDR: if (abort || tmr_tc) begin
        state_d  = abort ? S_GAP_D : S_GAP_A;
        tmr_load = 1'b1;
        tmr_val  = PH_W'(T_GAP);
      end
      S_GAP_A: if (abort) begin
        state_d  = S_GAP_D;
        tmr_load = 1'b1;
        tmr_val  = PH_W'(T_GAP);
      end else if (tmr_tc) begin
        state_d  = S_DATA;
        tmr_load = 1'b1;
        wtake_d  = ~rw_q;
      end
      S_DATA: if (abort || tmr_tc) begin
        state_d  = S_GAP_D;
        tmr_load = 1'b1;
        tmr_val  = PH_W'(T_GAP);
        rvalid_d = rw_q & ~abort;
      end
      S_GAP_D: if (tmr_tc) begin
        if (more && !abort_any) begin
          state_d  = S_ADDR;
          tmr_load = 1'b1;
          addr_d   = addr_q + DATA_W'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so pins change exactly on state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      abort_seen_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      wtake_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      bus_out_q    <= '0;
      bus_oe_q     <= 1'b0;
      ad_n_q       <= STROBE_OFF;
      cs_n_q       <= STROBE_OFF;
      rd_n_q       <= STROBE_OFF;
      wr_n_q       <= STROBE_OFF;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (state_q == S_IDLE && req) begin
        rw_q         <= rw;
        len_q        <= (burst_len == '0) ? LEN_W'(1) : burst_len;
        beat_q       <= '0;
        abort_seen_q <= 1'b0;
      end else if (state_q != S_IDLE && state_q != S_DONE) begin
        abort_seen_q <= abort_any;
      end
      if (state_q == S_GAP_D && state_d == S_ADDR) begin
        beat_q <= beat_nx[LEN_W-1:0];
      end
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      aborted_q <= (state_d == S_DONE) && abort_any;
      wtake_q   <= wtake_d;
      rvalid_q  <= rvalid_d;
      if (rvalid_d) begin
        rdata_q <= bus_in;
      end
      case (state_d)
        S_ADDR: begin
          cs_n_q    <= STROBE_ON;
          ad_n_q    <= STROBE_ON;
          wr_n_q    <= STROBE_ON;
          rd_n_q    <= STROBE_OFF;
          bus_oe_q  <= 1'b1;
          bus_out_q <= addr_d;
        end
        S_DATA: begin
          cs_n_q   <= STROBE_ON;
          ad_n_q   <= STROBE_OFF;
          rd_n_q   <= rw_q ? STROBE_ON : STROBE_OFF;
          wr_n_q   <= rw_q ? STROBE_OFF : STROBE_ON;
          bus_oe_q <= ~rw_q;
          if (wtake_d) begin
            bus_out_q <= wdata;
          end
        end
        default: begin
          cs_n_q   <= STROBE_OFF;
          ad_n_q   <= STROBE_OFF;
          rd_n_q   <= STROBE_OFF;
          wr_n_q   <= STROBE_OFF;
          bus_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign wtake       = wtake_q;
  assign rdata_valid = rvalid_q;
  assign rdata       = rdata_q;
  assign bus_out     = bus_out_q;
  assign bus_oe      = bus_oe_q;
  assign ad_n        = ad_n_q;
  assign cs_n        = cs_n_q;
  assign rd_n        = rd_n_q;
  assign wr_n        = wr_n_q;

endmodule

// File: tb/tb_rtc_bus_master.sv
// Bench for rtc_bus_master: directed table, randomized transactions against a phase-schedule model,
// plus reset-mid-transaction and a short-phase instance with req held high.
module tb_rtc_bus_master;

  localparam int P    = 4;
  localparam int G    = 2;
  localparam int MAXC = 256;

  typedef struct packed {
    logic       ad_n, cs_n, rd_n, wr_n, oe;
    logic [7:0] bout;
    logic       busy, done, aborted, wtake, rvalid;
    logic [7:0] rdata;
  } exp_t;

  typedef struct {
    bit         rw;
    logic [7:0] a;
    int         len, ab, hold;
    bit         use_c;
    logic [7:0] cval;
    int         e_done;
    bit         e_ab;
    int         e_wt, e_rv;
    logic [7:0] e_rdata;
  } vec_t;

  logic       clk = 1'b0, rst = 1'b1;
  logic       req = 1'b0, req2 = 1'b0, rw = 1'b0, abort = 1'b0;
  logic [7:0] addr = '0, wdata = '0, bus_in = '0;
  logic [3:0] burst_len = '0;
  logic       wtake, busy, done, aborted, rdata_valid, ad_n, cs_n, rd_n, wr_n, bus_oe;
  logic [7:0] rdata, bus_out;
  logic       wtake2, busy2, done2, aborted2, rdata_valid2, ad_n2, cs_n2, rd_n2, wr_n2, bus_oe2;
  logic [7:0] rdata2, bus_out2;

  int n_cmp = 0, n_fail = 0;

  exp_t       ex[MAXC];
  logic [7:0] bin[MAXC], drv_w[MAXC], rv_dat[MAXC], wv[16];
  logic [7:0] m_rdata = '0;
  vec_t       tbl[10];

  always #5 clk = ~clk;

  rtc_bus_master u_dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .burst_len(burst_len),
    .wdata(wdata), .wtake(wtake), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .rdata(rdata), .rdata_valid(rdata_valid), .ad_n(ad_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
  );

  rtc_bus_master #(.T_PULSE(1), .T_GAP(1)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .rw(rw), .addr(addr), .burst_len(burst_len),
    .wdata(wdata), .wtake(wtake2), .abort(abort), .busy(busy2), .done(done2), .aborted(aborted2),
    .rdata(rdata2), .rdata_valid(rdata_valid2), .ad_n(ad_n2), .cs_n(cs_n2), .rd_n(rd_n2),
    .wr_n(wr_n2), .bus_out(bus_out2), .bus_oe(bus_oe2), .bus_in(bus_in)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Expected trace from the phase schedule: beats of ADDR/GAP_A/DATA/GAP_D, truncated by abort.
  task automatic build(input bit rwi, input logic [7:0] a0, input int len, input int abc,
                       output int dc);
    int t, n;
    bit ab;
    logic [7:0] cur;
    n = (len == 0) ? 1 : len;
    for (int i = 0; i < MAXC; i++) begin
      ex[i] = '0;
      ex[i].ad_n = 1; ex[i].cs_n = 1; ex[i].rd_n = 1; ex[i].wr_n = 1;
      rv_dat[i] = '0;
      drv_w[i]  = 8'($urandom);
    end
    drv_w[0] = wv[0];
    t = 1; ab = 0;
    for (int b = 0; b < n && !ab; b++) begin
      for (int i = 0; i < P && !ab; i++) begin
        ex[t].busy = 1; ex[t].cs_n = 0; ex[t].ad_n = 0; ex[t].wr_n = 0; ex[t].oe = 1;
        ex[t].bout = a0 + 8'(b); drv_w[t] = wv[b];
        if (t == abc) ab = 1;
        t++;
      end
      for (int i = 0; i < G && !ab; i++) begin
        ex[t].busy = 1; drv_w[t] = wv[b];
        if (t == abc) ab = 1;
        t++;
      end
      for (int i = 0; i < P && !ab; i++) begin
        ex[t].busy = 1; ex[t].cs_n = 0; drv_w[t] = wv[b];
        if (rwi) ex[t].rd_n = 0;
        else begin
          ex[t].wr_n = 0; ex[t].oe = 1; ex[t].bout = wv[b]; ex[t].wtake = (i == 0);
        end
        if (t == abc) ab = 1;
        else if (rwi && i == P - 1) begin
          ex[t+1].rvalid = 1; rv_dat[t+1] = bin[t];
        end
        t++;
      end
      for (int i = 0; i < G; i++) begin
        ex[t].busy = 1; drv_w[t] = wv[b];
        if (t == abc) ab = 1;
        t++;
      end
    end
    ex[t].busy = 1; ex[t].done = 1; ex[t].aborted = ab;
    dc = t;
    cur = m_rdata;
    for (int i = 1; i < MAXC; i++) begin
      if (ex[i].rvalid) cur = rv_dat[i];
      ex[i].rdata = cur;
    end
    m_rdata = cur;
  endtask

  task automatic run_txn(input bit rwi, input logic [7:0] a0, input int len, input int abc,
                         input int hold_in, input bit use_c, input logic [7:0] cval,
                         output int o_done, output bit o_ab, output int o_wt, output int o_rv);
    int dc, hold;
    exp_t act;
    for (int i = 0; i < 16; i++) wv[i] = use_c ? cval : 8'($urandom);
    for (int i = 0; i < MAXC; i++) bin[i] = use_c ? cval : 8'($urandom);
    build(rwi, a0, len, abc, dc);
    hold = (hold_in > dc) ? dc : hold_in;
    rw = rwi; addr = a0; burst_len = len[3:0];
    o_done = -1; o_ab = 0; o_wt = 0; o_rv = 0;
    for (int t = 0; t <= dc + 1; t++) begin
      req = (t <= hold); abort = (t == abc); wdata = drv_w[t]; bus_in = bin[t];
      step();
      act = {ad_n, cs_n, rd_n, wr_n, bus_oe, bus_out, busy, done, aborted, wtake, rdata_valid, rdata};
      if (!ex[t+1].oe) act.bout = ex[t+1].bout;
      chk($sformatf("cyc%0d", t + 1), 64'(act), 64'(ex[t+1]));
      if (done && o_done < 0) begin o_done = t + 1; o_ab = aborted; end
      o_wt += int'(wtake);
      o_rv += int'(rdata_valid);
    end
    req = 0; abort = 0;
  endtask

  initial begin
    int od, owt, orv, n, nom, ab, hold;
    bit oab;
    logic [7:0] e2f[8], e2b[8], a2;

    tbl[0] = '{0, 8'h21, 1, -1,  0, 1, 8'h5A, 13, 0, 1, 0, 8'h00};
    tbl[1] = '{1, 8'h01, 1, -1,  0, 1, 8'h37, 13, 0, 0, 1, 8'h37};
    tbl[2] = '{1, 8'hFE, 3, -1,  5, 0, 8'h00, 37, 0, 0, 3, 8'h00};
    tbl[3] = '{0, 8'h10, 4,  5,  2, 0, 8'h00,  8, 1, 0, 0, 8'h00};
    tbl[4] = '{0, 8'h80, 0, -1, 13, 0, 8'h00, 13, 0, 1, 0, 8'h00};
    tbl[5] = '{1, 8'h55, 2,  0,  0, 0, 8'h00, 25, 0, 0, 2, 8'h00};
    tbl[6] = '{0, 8'h7F, 2, 15,  0, 0, 8'h00, 18, 1, 1, 0, 8'h00};
    tbl[7] = '{1, 8'hC3, 1,  9,  0, 0, 8'h00, 12, 1, 0, 0, 8'h00};
    tbl[8] = '{0, 8'h00, 3, 12,  3, 0, 8'h00, 13, 1, 1, 0, 8'h00};
    tbl[9] = '{1, 8'hFF, 2, 11,  0, 1, 8'hA5, 13, 1, 0, 1, 8'hA5};

    rst = 1;
    step(); step();
    chk("reset_state",
        64'({ad_n, cs_n, rd_n, wr_n, bus_oe, bus_out, busy, done, aborted, wtake, rdata_valid, rdata}),
        64'({5'b11110, 8'h00, 5'b00000, 8'h00}));
    rst = 0;
    step();

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].rw, tbl[i].a, tbl[i].len, tbl[i].ab, tbl[i].hold, tbl[i].use_c, tbl[i].cval,
              od, oab, owt, orv);
      chk($sformatf("v%0d_done_cyc", i), 64'(od), 64'(tbl[i].e_done));
      chk($sformatf("v%0d_aborted", i), 64'(oab), 64'(tbl[i].e_ab));
      chk($sformatf("v%0d_wtakes", i), 64'(owt), 64'(tbl[i].e_wt));
      chk($sformatf("v%0d_rvalids", i), 64'(orv), 64'(tbl[i].e_rv));
      if (tbl[i].use_c && tbl[i].rw) chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(tbl[i].e_rdata));
    end

    for (int k = 0; k < 40; k++) begin
      n   = $urandom_range(0, 5);
      nom = ((n == 0) ? 1 : n) * 2 * (P + G) + 1;
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nom) : -1;
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nom) : 0;
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), n, ab, hold, 0, 8'h00, od, oab, owt, orv);
      if ($urandom_range(0, 3) == 0) step();
    end

    // Reset in the middle of a write DATA phase.
    rw = 0; addr = 8'h33; wdata = 8'h44; burst_len = 4'd1; req = 1;
    step();
    req = 0;
    for (int i = 0; i < 7; i++) step();
    chk("pre_rst_wr_n", 64'(wr_n), 64'(0));
    rst = 1;
    #1;
    chk("rst_async_outs", 64'({ad_n, cs_n, rd_n, wr_n, bus_oe, busy, rdata}), 64'({6'b111100, 8'h00}));
    #1;
    rst = 0;
    m_rdata = '0;
    step();
    run_txn(0, 8'h21, 1, -1, 0, 1, 8'h5A, od, oab, owt, orv);
    chk("post_rst_done_cyc", 64'(od), 64'(13));

    // Short-phase instance, burst_len=0, req held high through the transaction.
    e2f[1] = 8'b00101100; e2f[2] = 8'b11110100; e2f[3] = 8'b10101101; e2f[4] = 8'b11110100;
    e2f[5] = 8'b11110110; e2f[6] = 8'b11110000; e2f[7] = 8'b11110000;
    e2b[1] = 8'h40; e2b[2] = 8'h00; e2b[3] = 8'h99; e2b[4] = 8'h00;
    e2b[5] = 8'h00; e2b[6] = 8'h00; e2b[7] = 8'h00;
    rw = 0; addr = 8'h40; burst_len = 4'd0; wdata = 8'h99;
    for (int t = 0; t <= 6; t++) begin
      req2 = (t <= 5);
      step();
      a2 = bus_oe2 ? bus_out2 : 8'h00;
      chk($sformatf("p1_cyc%0d", t + 1),
          64'({ad_n2, cs_n2, rd_n2, wr_n2, bus_oe2, busy2, done2, wtake2, a2}),
          64'({e2f[t+1], e2b[t+1]}));
    end
    req2 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
